zynq_dna_usr_data: RTL and testbench
====================================

// Module: zynq_dna_usr_data
// PURPOSE
//  APB3 slave exposing the 57-bit device DNA and the 32-bit USR_ACCESS word to the PS.
//  After reset a capture FSM serially reads the DNA port once; DNA-register reads stall (PREADY low) until capture completes.
//  Sits on a PS GP-AXI->APB bridge in the board controller.
// PARAMETERS
//  DNA_CLK_HALF    2                    APB_aclk cycles per dna_clk half-period (>=1)
//  SIM_DNA_VALUE   57'h1_2345_6789_ABCD_EF  DNA returned by the behavioural model
//  SIM_USR_ACCESS  32'h5A5A_0001        USR_ACCESS returned by the behavioural model
// PORTS
//  APB_aclk     in   1   sole clock
//  APB_areset   in   1   synchronous, active-high reset
//  APB_paddr    in   32  byte address; only [4:2] decoded
//  APB_psel     in   1   slave select
//  APB_penable  in   1   access phase
//  APB_pwrite   in   1   1=write, 0=read
//  APB_pwdata   in   32  write data (ignored)
//  APB_prdata   out  32  read data
//  APB_pready   out  1   transfer complete
//  APB_pslverr  out  1   error response
// BEHAVIOUR
//  Reset: prdata=0, pready=0, pslverr=0, dna_valid=0, dna=0, FSM=IDLE, dna_clk=0.
//  Register map (reads): 0x00 STATUS {16'h444E,15'b0,dna_valid}; 0x04 DNA[31:0];
//   0x08 {7'b0,DNA[56:32]}; 0x0C USR_ACCESS; 0x10-0x1C read 0 with pslverr=1.
//  APB: pready/prdata/pslverr combinational, valid only when psel&penable; else all 0.
//   STATUS/USR/unmapped: zero-wait (pready=1 in first access cycle).
//   0x04/0x08 with dna_valid=0: pready=0 until dna_valid=1, then completes same cycle.
//   Writes: any address, zero-wait, no side effect, pslverr=1.
//  Capture FSM: IDLE->LOAD->SHIFT->DONE, starts first cycle after reset deasserts.
//   dna_clk toggles every DNA_CLK_HALF aclk cycles while FSM not IDLE/DONE.
//   LOAD: dna_read=1 for one dna_clk rising edge (port loads DNA, dout=bit 56).
//   SHIFT: dna_shift=1; on each of 57 dna_clk rising edges sample dout into
//    dna<= {dna[55:0],dout} before port shifts; din tied 0. After 57th -> DONE.
//   DONE: dna_valid=1, dna_clk held 0, FSM idle until next reset.
//  Reset mid-capture or mid-transfer: aborts; capture restarts from LOAD.
//  USR_ACCESS sampled once per aclk into a register (static value).
// CONFIGURATION
//  ZYNQ_PRIMITIVES_EN defined: instantiate DNA_PORT and USR_ACCESSE2 vendor primitives.
//  Undefined: behavioural DNA model (57-bit shift reg loaded with SIM_DNA_VALUE on
//   read, shifts left on shift edges, dout=bit 56) and USR_ACCESS=SIM_USR_ACCESS.
//  Register map, FSM and APB timing identical in both builds.
// STRUCTURE
//  Package zynq_dna_usr_data_pkg: register offsets, STATUS magic 16'h444E, DNA_W=57,
//   FSM state enum.
//  Sub-module zynq_dna_reader: capture FSM + dna_clk divider + primitive/model
//   (ports: clk, rst, dna[56:0], dna_valid). Top holds APB decode and USR_ACCESS.
// TESTING (default params, model build)
//  Reset 5 cycles, read 0x08 -> pready low >=200 cycles, then 1 with prdata=32'h0123_4567.
//  After capture read 0x04 -> zero-wait, prdata=32'h89AB_CDEF, pslverr=0.
//  Read 0x00 right after reset -> 32'h444E_0000; after capture -> 32'h444E_0001.
//  Read 0x0C -> zero-wait, prdata=32'h5A5A_0001.
//  Write 0x04 data 32'hFFFF_FFFF -> pready=1, pslverr=1; reread 0x04 unchanged.
//  Assert reset mid-capture, release -> status bit0=0, re-capture yields same DNA.

Source files
------------

// File: rtl/zynq_dna_usr_data_pkg.sv
// ============================================================================
// Module      : zynq_dna_usr_data_pkg
// Description : Shared constants, register word indices and capture FSM states
//               for the DNA / USR_ACCESS APB slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package zynq_dna_usr_data_pkg;

   localparam int unsigned DNA_W        = 57;
   localparam logic [15:0] STATUS_MAGIC = 16'h444E;

   // Word index = APB_paddr[4:2]
   localparam logic [2:0] REG_STATUS = 3'd0;
   localparam logic [2:0] REG_DNA_LO = 3'd1;
   localparam logic [2:0] REG_DNA_HI = 3'd2;
   localparam logic [2:0] REG_USR    = 3'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } dna_state_t;

endpackage

`default_nettype wire

// File: rtl/zynq_dna_reader.sv
// ============================================================================
// Module      : zynq_dna_reader
// Description : One-shot serial capture of the 57-bit device DNA after reset.
//               ZYNQ_PRIMITIVES_EN selects DNA_PORT, otherwise a behavioural
//               shift-register model stands in for it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module zynq_dna_reader
   import zynq_dna_usr_data_pkg::*;
#(
   parameter int unsigned        DNA_CLK_HALF  = 2,
   parameter logic [DNA_W-1:0]   SIM_DNA_VALUE = 57'h1_2345_6789_ABCD_EF
) (
   input  logic               clk,
   input  logic               rst,
   output logic [DNA_W-1:0]   dna,
   output logic               dna_valid
);

   localparam int unsigned DIV_W = $clog2(DNA_CLK_HALF + 1);
   localparam logic [DIV_W-1:0] c_div_last = DIV_W'(DNA_CLK_HALF - 1);
   localparam logic [5:0]       c_bit_last = 6'(DNA_W - 1);

   dna_state_t        r_state;
   logic [DIV_W-1:0]  r_div;
   logic              r_dna_clk;
   logic [5:0]        r_bit;
   logic [DNA_W-1:0]  r_dna;
   logic              r_dna_valid;

   logic w_run;
   logic w_tick;
   logic w_rise;
   logic w_read;
   logic w_shift;
   logic w_dout;

   assign w_run   = (r_state == ST_LOAD) || (r_state == ST_SHIFT);
   assign w_tick  = w_run && (r_div == c_div_last);
   assign w_rise  = w_tick && !r_dna_clk;
   assign w_read  = (r_state == ST_LOAD);
   assign w_shift = (r_state == ST_SHIFT);

`ifdef ZYNQ_PRIMITIVES_EN
   DNA_PORT #(
      .SIM_DNA_VALUE (SIM_DNA_VALUE)
   ) u_dna_port (
      .DOUT  (w_dout),
      .CLK   (r_dna_clk),
      .DIN   (1'b0),
      .READ  (w_read),
      .SHIFT (w_shift)
   );
`else
   logic [DNA_W-1:0] r_model_sr;

   // Updates on the same aclk edge that raises dna_clk, so w_dout is still pre-shift.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_model_sr <= '0;
      end else if (w_rise) begin
         if (w_read)
            r_model_sr <= SIM_DNA_VALUE;
         else if (w_shift)
            r_model_sr <= {r_model_sr[DNA_W-2:0], 1'b0};
      end
   end

   assign w_dout = r_model_sr[DNA_W-1];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_div       <= '0;
         r_dna_clk   <= 1'b0;
         r_bit       <= '0;
         r_dna       <= '0;
         r_dna_valid <= 1'b0;
      end else begin
         if (w_run) begin
            if (w_tick) begin
               r_div     <= '0;
               r_dna_clk <= ~r_dna_clk;
            end else begin
               r_div <= r_div + 1'b1;
            end
         end

         case (r_state)
            ST_IDLE: begin
               r_state   <= ST_LOAD;
               r_div     <= '0;
               r_dna_clk <= 1'b0;
            end
            ST_LOAD: begin
               if (w_rise) begin
                  r_state <= ST_SHIFT;
                  r_bit   <= '0;
               end
            end
            ST_SHIFT: begin
               if (w_rise) begin
                  r_dna <= {r_dna[DNA_W-2:0], w_dout};
                  if (r_bit == c_bit_last) begin
                     r_state     <= ST_DONE;
                     r_dna_valid <= 1'b1;
                     r_dna_clk   <= 1'b0;
                     r_div       <= '0;
                  end else begin
                     r_bit <= r_bit + 1'b1;
                  end
               end
            end
            default: begin
               r_dna_clk <= 1'b0;
            end
         endcase
      end
   end

   assign dna       = r_dna;
   assign dna_valid = r_dna_valid;

endmodule

`default_nettype wire

// File: rtl/zynq_dna_usr_data.sv
// ============================================================================
// Module      : zynq_dna_usr_data
// Description : APB3 slave returning device DNA, USR_ACCESS and a status word.
//               ZYNQ_PRIMITIVES_EN selects USR_ACCESSE2/DNA_PORT primitives.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module zynq_dna_usr_data
   import zynq_dna_usr_data_pkg::*;
#(
   parameter int unsigned       DNA_CLK_HALF   = 2,
   parameter logic [DNA_W-1:0]  SIM_DNA_VALUE  = 57'h1_2345_6789_ABCD_EF,
   parameter logic [31:0]       SIM_USR_ACCESS = 32'h5A5A_0001
) (
   input  logic        APB_aclk,
   input  logic        APB_areset,
   input  logic [31:0] APB_paddr,
   input  logic        APB_psel,
   input  logic        APB_penable,
   input  logic        APB_pwrite,
   input  logic [31:0] APB_pwdata,
   output logic [31:0] APB_prdata,
   output logic        APB_pready,
   output logic        APB_pslverr
);

   logic [DNA_W-1:0] w_dna;
   logic             w_dna_valid;
   logic [31:0]      w_usr;
   logic [31:0]      r_usr;
   logic [2:0]       w_idx;
   logic             w_access;
   logic             w_unused;

   zynq_dna_reader #(
      .DNA_CLK_HALF  (DNA_CLK_HALF),
      .SIM_DNA_VALUE (SIM_DNA_VALUE)
   ) u_reader (
      .clk       (APB_aclk),
      .rst       (APB_areset),
      .dna       (w_dna),
      .dna_valid (w_dna_valid)
   );

`ifdef ZYNQ_PRIMITIVES_EN
   USR_ACCESSE2 u_usr_access (
      .DATA (w_usr)
   );
`else
   assign w_usr = SIM_USR_ACCESS;
`endif

   always_ff @(posedge APB_aclk) begin
      if (APB_areset)
         r_usr <= '0;
      else
         r_usr <= w_usr;
   end

   assign w_idx    = APB_paddr[4:2];
   assign w_access = APB_psel && APB_penable && !APB_areset;
   assign w_unused = ^{APB_pwdata, APB_paddr[31:5], APB_paddr[1:0]};

   // DNA words hold the transfer (pready low) until capture has finished.
   always_comb begin
      APB_prdata  = '0;
      APB_pready  = 1'b0;
      APB_pslverr = 1'b0;
      if (w_access) begin
         if (APB_pwrite) begin
            APB_pready  = 1'b1;
            APB_pslverr = 1'b1;
         end else begin
            case (w_idx)
               REG_STATUS: begin
                  APB_pready = 1'b1;
                  APB_prdata = {STATUS_MAGIC, 15'b0, w_dna_valid};
               end
               REG_DNA_LO: begin
                  APB_pready = w_dna_valid;
                  if (w_dna_valid)
                     APB_prdata = w_dna[31:0];
               end
               REG_DNA_HI: begin
                  APB_pready = w_dna_valid;
                  if (w_dna_valid)
                     APB_prdata = {7'b0, w_dna[DNA_W-1:32]};
               end
               REG_USR: begin
                  APB_pready = 1'b1;
                  APB_prdata = r_usr;
               end
               default: begin
                  APB_pready  = 1'b1;
                  APB_pslverr = 1'b1;
               end
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_zynq_dna_usr_data.sv
// ============================================================================
// Module      : tb_zynq_dna_usr_data
// Description : Self-checking bench for zynq_dna_usr_data (behavioural build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_zynq_dna_usr_data;

   logic        clk;
   logic        rst;
   logic [31:0] paddr;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rdata;
      logic        err;
      int          min_w;
      int          max_w;
   } vec_t;

   vec_t sb[$];
   vec_t tbl[14];

   zynq_dna_usr_data dut (
      .APB_aclk    (clk),
      .APB_areset  (rst),
      .APB_paddr   (paddr),
      .APB_psel    (psel),
      .APB_penable (penable),
      .APB_pwrite  (pwrite),
      .APB_pwdata  (pwdata),
      .APB_prdata  (prdata),
      .APB_pready  (pready),
      .APB_pslverr (pslverr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check_wait(input string nm, input int w, input int lo, input int hi);
      n_assert++;
      if (w < lo || w > hi) begin
         n_fail++;
         $display("FAIL %s waits: got %0d expected %0d..%0d", nm, w, lo, hi);
      end
   endtask

   // Push the expectation, run the transfer, pop and compare when pready arrives.
   task automatic run_vec(input string nm, input vec_t v);
      vec_t e;
      int   waits;
      logic [31:0] rd;
      logic err;
      int   budget;
      sb.push_back(v);
      budget = v.max_w + 50;
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = v.wr; paddr = v.addr; pwdata = v.wd;
      @(posedge clk); #1;
      penable = 1'b1;
      #1;
      waits = 0;
      while (!pready && waits < budget) begin
         @(posedge clk); #2;
         waits++;
      end
      rd  = prdata;
      err = pslverr;
      e   = sb.pop_front();
      n_assert++;
      if (!pready) begin
         n_fail++;
         $display("FAIL %s timeout: pready still 0 after %0d cycles, required 1", nm, waits);
      end else begin
         check({nm, " prdata"}, rd, e.rdata);
         check({nm, " pslverr"}, {31'b0, err}, {31'b0, e.err});
         check_wait(nm, waits, e.min_w, e.max_w);
      end
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic do_reset(input int cycles);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (cycles) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      vec_t v;
      tbl[0]  = '{1'b0, 32'h00, 32'h0, 32'h444E_0001, 1'b0, 0, 0};
      tbl[1]  = '{1'b0, 32'h04, 32'h0, 32'h89AB_CDEF, 1'b0, 0, 0};
      tbl[2]  = '{1'b0, 32'h08, 32'h0, 32'h0123_4567, 1'b0, 0, 0};
      tbl[3]  = '{1'b0, 32'h0C, 32'h0, 32'h5A5A_0001, 1'b0, 0, 0};
      tbl[4]  = '{1'b0, 32'h10, 32'h0, 32'h0,         1'b1, 0, 0};
      tbl[5]  = '{1'b0, 32'h14, 32'h0, 32'h0,         1'b1, 0, 0};
      tbl[6]  = '{1'b0, 32'h18, 32'h0, 32'h0,         1'b1, 0, 0};
      tbl[7]  = '{1'b0, 32'h1C, 32'h0, 32'h0,         1'b1, 0, 0};
      tbl[8]  = '{1'b1, 32'h04, 32'hFFFF_FFFF, 32'h0, 1'b1, 0, 0};
      tbl[9]  = '{1'b0, 32'h04, 32'h0, 32'h89AB_CDEF, 1'b0, 0, 0};
      tbl[10] = '{1'b1, 32'h00, 32'h1234_5678, 32'h0, 1'b1, 0, 0};
      tbl[11] = '{1'b0, 32'h00, 32'h0, 32'h444E_0001, 1'b0, 0, 0};
      tbl[12] = '{1'b0, 32'h24, 32'h0, 32'h89AB_CDEF, 1'b0, 0, 0};
      tbl[13] = '{1'b0, 32'h2C, 32'h0, 32'h5A5A_0001, 1'b0, 0, 0};

      rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0;

      // Access held during reset must see all-zero outputs.
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b1; paddr = 32'h0C;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("reset prdata", prdata, 32'h0);
      check("reset pready", {31'b0, pready}, 32'h0);
      check("reset pslverr", {31'b0, pslverr}, 32'h0);
      psel = 1'b0; penable = 1'b0; paddr = '0;
      @(posedge clk); #1;
      rst = 1'b0;

      // DNA high word right after reset stalls for the whole capture.
      v = '{1'b0, 32'h08, 32'h0, 32'h0123_4567, 1'b0, 200, 400};
      run_vec("early dna_hi", v);

      for (int i = 0; i < 14; i++)
         run_vec($sformatf("vec%0d", i), tbl[i]);

      // Reset mid-capture, then reset again part way through the restart.
      do_reset(3);
      repeat (40) @(posedge clk);
      do_reset(2);
      v = '{1'b0, 32'h00, 32'h0, 32'h444E_0000, 1'b0, 0, 0};
      run_vec("status after reset", v);
      v = '{1'b0, 32'h0C, 32'h0, 32'h5A5A_0001, 1'b0, 0, 0};
      run_vec("usr during capture", v);
      v = '{1'b0, 32'h04, 32'h0, 32'h89AB_CDEF, 1'b0, 150, 400};
      run_vec("recapture dna_lo", v);
      v = '{1'b0, 32'h08, 32'h0, 32'h0123_4567, 1'b0, 0, 0};
      run_vec("recapture dna_hi", v);
      v = '{1'b0, 32'h00, 32'h0, 32'h444E_0001, 1'b0, 0, 0};
      run_vec("status recaptured", v);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
